// File: rtl/dcache_ctrl_if.sv
// Core/memory-facing signal bundle of the data cache controller.
// master = core + memory side (drives requests/handshakes), slave = dcache_ctrl.
interface dcache_ctrl_if #(
  parameter int OFF_W = 2,
  parameter int CNT_W = 16
);
  logic             MemRead;
  logic             MemWrite;
  logic             hit;
  logic             mem_ready;
  logic             stall;
  logic             mem_rd;
  logic             mem_wr;
  logic             refill_we;
  logic [OFF_W-1:0] refill_off;
  logic             tag_we;
  logic             cache_wr_we;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output MemRead, MemWrite, hit, mem_ready,
    input  stall, mem_rd, mem_wr, refill_we, refill_off, tag_we, cache_wr_we, miss_cnt
  );

  modport slave (
    input  MemRead, MemWrite, hit, mem_ready,
    output stall, mem_rd, mem_wr, refill_we, refill_off, tag_we, cache_wr_we, miss_cnt
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Data cache sequencer: read-miss line refill, write-through/no-allocate stores, miss counter.
// Mealy outputs; read hit 0 extra cycles, miss 1+WORDS_PER_BLOCK ready cycles, store >=2; stalls on mem_ready=0.
module dcache_ctrl #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int OFF_W           = 2,
  parameter int CNT_W           = 16
) (
  input  logic           CLK,
  input  logic           RST,
  dcache_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_BLOCK - 1);

  state_t           state_q, state_d;
  logic [OFF_W-1:0] refill_off_q, refill_off_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      refill_off_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      refill_off_q <= refill_off_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    refill_off_d    = refill_off_q;
    miss_cnt_d      = miss_cnt_q;
    bus.stall       = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.refill_we   = 1'b0;
    bus.tag_we      = 1'b0;
    bus.cache_wr_we = 1'b0;

    case (state_q)
      IDLE: begin
        // Stores win over loads; asserting both is illegal but must stay deterministic.
        if (bus.MemWrite) begin
          bus.stall = 1'b1;
          state_d   = WRITE;
        end else if (bus.MemRead && !bus.hit) begin
          bus.stall    = 1'b1;
          state_d      = REFILL;
          refill_off_d = '0;
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end

      REFILL: begin
        bus.stall  = 1'b1;
        bus.mem_rd = 1'b1;
        if (bus.mem_ready) begin
          bus.refill_we = 1'b1;
          refill_off_d  = refill_off_q + 1'b1;
          // Valid only goes up with the last word, so an aborted refill leaves the line invalid.
          if (refill_off_q == LAST_OFF) begin
            bus.tag_we = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      WRITE: begin
        bus.mem_wr = 1'b1;
        bus.stall  = !bus.mem_ready;
        if (bus.mem_ready) begin
          bus.cache_wr_we = bus.hit;
          state_d         = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.refill_off = refill_off_q;
  assign bus.miss_cnt   = miss_cnt_q;

endmodule
